// File: rtl/button_counter.sv
`default_nettype none
// ============================================================================
// Module   : button_counter
// Brief    : two debounced push buttons step a 4-bit count; a switch loads it
// Revision : 1.0
// ============================================================================
module button_counter #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_UP,
  input  logic       KEY_DN,
  input  logic       LOAD,
  input  logic [3:0] SW,
  output logic [3:0] bin,
  output logic       changed
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // Key vectors: bit 0 is the up key, bit 1 is the down key.
  logic [1:0]              key_meta_q, key_meta_d;
  logic [1:0]              key_sync_q, key_sync_d;
  logic                    load_meta_q, load_meta_d;
  logic                    load_sync_q, load_sync_d;
  logic [3:0]              sw_meta_q, sw_meta_d;
  logic [3:0]              sw_sync_q, sw_sync_d;
  logic [1:0]              level_q, level_d;
  logic [1:0]              press_q, press_d;
  logic [1:0][c_cnt_w-1:0] cnt_q, cnt_d;
  logic [3:0]              bin_q, bin_d;
  logic                    changed_q, changed_d;

  always_comb begin
    key_meta_d  = {KEY_DN, KEY_UP};
    key_sync_d  = key_meta_q;
    load_meta_d = LOAD;
    load_sync_d = load_meta_q;
    sw_meta_d   = SW;
    sw_sync_d   = sw_meta_q;
  end

  // Debounce runs regardless of LOAD so a press made during a load is consumed.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (key_sync_q[k] == level_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == c_cnt_last) begin
        cnt_d[k]   = '0;
        level_d[k] = key_sync_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + c_cnt_one;
      end
      press_d[k] = level_q[k] & ~level_d[k];
    end
  end

  always_comb begin
    bin_d = bin_q;
    if (load_sync_q) begin
      bin_d = sw_sync_q;
    end else if (press_q == 2'b01) begin
      bin_d = bin_q + 4'd1;
    end else if (press_q == 2'b10) begin
      bin_d = bin_q - 4'd1;
    end
    changed_d = (bin_d != bin_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_meta_q  <= 2'b11;
      key_sync_q  <= 2'b11;
      load_meta_q <= 1'b0;
      load_sync_q <= 1'b0;
      sw_meta_q   <= 4'd0;
      sw_sync_q   <= 4'd0;
      level_q     <= 2'b11;
      press_q     <= 2'b00;
      cnt_q       <= '0;
      bin_q       <= 4'd0;
      changed_q   <= 1'b0;
    end else begin
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      load_meta_q <= load_meta_d;
      load_sync_q <= load_sync_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      level_q     <= level_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      changed_q   <= changed_d;
    end
  end

  assign bin     = bin_q;
  assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_button_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_counter
// Brief    : directed scenarios plus random stimulus against a window model
// Revision : 1.0
// ============================================================================
module tb_button_counter;

  localparam int DB = 4;
  localparam logic [6:0] c_raw_rst = 7'b000_0011;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       KEY_UP;
  logic       KEY_DN;
  logic       LOAD;
  logic [3:0] SW;
  logic [3:0] bin;
  logic       changed;

  int total = 0;
  int bad   = 0;

  // Reference model state. Raw sample packing: {LOAD, SW[3:0], KEY_DN, KEY_UP}.
  logic [6:0]    pipe [2];
  logic [DB-1:0] hist [2];
  logic [1:0]    lvl;
  logic [1:0]    pend;
  logic [3:0]    m_bin;
  logic          m_chg;

  button_counter #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY_UP   (KEY_UP),
    .KEY_DN   (KEY_DN),
    .LOAD     (LOAD),
    .SW       (SW),
    .bin      (bin),
    .changed  (changed)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // A key's accepted level flips once the last DB synchronized samples all
  // disagree with it; a press is a released->pressed flip, applied one edge later.
  task automatic model_edge();
    logic [6:0] s;
    logic [1:0] fell;
    int         nb;
    if (RESET) begin
      pipe[0] = c_raw_rst;
      pipe[1] = c_raw_rst;
      hist[0] = '1;
      hist[1] = '1;
      lvl     = 2'b11;
      pend    = 2'b00;
      m_bin   = 4'd0;
      m_chg   = 1'b0;
      return;
    end
    s       = pipe[0];
    pipe[0] = pipe[1];
    pipe[1] = {LOAD, SW, KEY_DN, KEY_UP};
    nb = int'(m_bin);
    if (s[6])                nb = int'(s[5:2]);
    else if (pend == 2'b01)  nb = (nb + 1) % 16;
    else if (pend == 2'b10)  nb = (nb + 15) % 16;
    m_chg = (4'(nb) != m_bin);
    m_bin = 4'(nb);
    fell  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      hist[k] = {hist[k][DB-2:0], s[k]};
      if (hist[k] == {DB{~lvl[k]}}) begin
        fell[k] = lvl[k];
        lvl[k]  = ~lvl[k];
      end
    end
    pend = fell;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      model_edge();
      #1;
      check("bin_vs_model", {4'd0, bin}, {4'd0, m_bin});
      check("changed_vs_model", {7'd0, changed}, {7'd0, m_chg});
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    RESET = 1'b1; KEY_UP = 1'b1; KEY_DN = 1'b1; LOAD = 1'b0; SW = 4'd0;

    // Reset state
    tick(3);
    check("reset_bin", {4'd0, bin}, 8'd0);
    check("reset_changed", {7'd0, changed}, 8'd0);
    RESET = 1'b0;
    tick(2);

    // Clean up press: bin changes exactly DB+3 edges after the fall
    KEY_UP = 1'b0;
    tick(DB + 2);
    check("press_not_early", {4'd0, bin}, 8'd0);
    tick(1);
    check("press_bin", {4'd0, bin}, 8'd1);
    check("press_changed", {7'd0, changed}, 8'd1);
    tick(1);
    check("press_changed_one_cycle", {7'd0, changed}, 8'd0);
    tick(10);
    check("held_counts_once", {4'd0, bin}, 8'd1);
    KEY_UP = 1'b1;
    tick(10);
    check("release_no_count", {4'd0, bin}, 8'd1);

    // Bounce: low 2 / high 1, four times
    for (int r = 0; r < 4; r++) begin
      KEY_UP = 1'b0; tick(1);
      check("bounce_changed", {7'd0, changed}, 8'd0);
      tick(1);
      check("bounce_changed", {7'd0, changed}, 8'd0);
      KEY_UP = 1'b1; tick(1);
      check("bounce_changed", {7'd0, changed}, 8'd0);
    end
    tick(8);
    check("bounce_bin", {4'd0, bin}, 8'd1);

    // Wrap up and down
    LOAD = 1'b1; SW = 4'd15;
    tick(4);
    LOAD = 1'b0;
    tick(4);
    check("load15_bin", {4'd0, bin}, 8'd15);
    KEY_UP = 1'b0;
    tick(DB + 3);
    check("wrap_up_bin", {4'd0, bin}, 8'd0);
    check("wrap_up_changed", {7'd0, changed}, 8'd1);
    KEY_UP = 1'b1;
    tick(8);
    KEY_DN = 1'b0;
    tick(DB + 3);
    check("wrap_dn_bin", {4'd0, bin}, 8'd15);
    check("wrap_dn_changed", {7'd0, changed}, 8'd1);
    KEY_DN = 1'b1;
    tick(8);

    // Simultaneous presses cancel
    LOAD = 1'b1; SW = 4'd7;
    tick(4);
    LOAD = 1'b0;
    tick(4);
    KEY_UP = 1'b0; KEY_DN = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("simul_bin", {4'd0, bin}, 8'd7);
      check("simul_changed", {7'd0, changed}, 8'd0);
    end
    KEY_UP = 1'b1; KEY_DN = 1'b1;
    tick(8);

    // Press completing during load is discarded
    LOAD = 1'b1; SW = 4'd9;
    tick(3);
    KEY_UP = 1'b0;
    tick(8);
    check("load_vs_press_bin", {4'd0, bin}, 8'd9);
    LOAD = 1'b0;
    tick(5);
    check("no_stale_press", {4'd0, bin}, 8'd9);
    KEY_UP = 1'b1;
    tick(8);
    KEY_UP = 1'b0;
    tick(DB + 3);
    check("press_after_load", {4'd0, bin}, 8'd10);
    KEY_UP = 1'b1;
    tick(8);

    // Reset in the middle of a down-key debounce
    KEY_DN = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(1);
    check("midreset_bin", {4'd0, bin}, 8'd0);
    RESET = 1'b0;
    tick(DB + 2);
    check("midreset_no_early", {4'd0, bin}, 8'd0);
    tick(1);
    check("midreset_dn_bin", {4'd0, bin}, 8'd15);
    check("midreset_dn_changed", {7'd0, changed}, 8'd1);
    KEY_DN = 1'b1;
    tick(8);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(5) == 0)   KEY_UP = ~KEY_UP;
      if ($urandom_range(5) == 0)   KEY_DN = ~KEY_DN;
      if ($urandom_range(39) == 0)  LOAD = ~LOAD;
      if ($urandom_range(9) == 0)   SW = 4'($urandom);
      RESET = ($urandom_range(299) == 0);
      tick(1);
    end
    RESET = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_counter.md
BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Port: CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: KEY_UP  input  1  raw, asynchronous, active-low push button; a press increments the count.
REQ-005 Port: KEY_DN  input  1  raw, asynchronous, active-low push button; a press decrements the count.
REQ-006 Port: LOAD  input  1  level, asynchronous slide switch; while high, the count follows SW.
REQ-007 Port: SW  input  4  load value; quasi-static, but sampled through the same synchronizer as LOAD.
REQ-008 Port: bin  output  4  registered unsigned count 0..15, fed to the decimal-display stage downstream.
REQ-009 Port: changed  output  1  registered one-cycle pulse, high for one cycle after bin changes value.

Function
REQ-010 Synchronization: KEY_UP, KEY_DN, LOAD and SW[3:0] SHALL each pass through a two-flop synchronizer before any use.
REQ-011 Per key, the block SHALL keep a debounced level (reset 1 = released) and a debounce counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-012 Counter reset: the counter SHALL clear to 0 on every cycle the synchronized key equals the debounced level.
REQ-013 Counter advance: the counter SHALL increment on every cycle the synchronized key differs from the debounced level.
REQ-014 Level acceptance: when the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-015 Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no debounced change.
REQ-016 Press event: a debounced 1->0 transition SHALL generate exactly one internal press event; a 0->1 release SHALL generate none.
REQ-017 Held key: holding a key pressed indefinitely SHALL count once.
REQ-018 Press latency: with a raw key held low from clock edge t, bin SHALL update at edge t+DEBOUNCE_CYCLES+3.
REQ-019 Up press: an up event alone SHALL set bin to (bin+1) mod 16, so 15 wraps to 0.
REQ-020 Down press: a down event alone SHALL set bin to (bin-1) mod 16, so 0 wraps to 15.
REQ-021 Simultaneous presses: up and down events in the same cycle SHALL leave bin unchanged.
REQ-022 Load priority: while synchronized LOAD=1, bin SHALL load synchronized SW every cycle.
REQ-023 Load discard: press events occurring while synchronized LOAD=1 SHALL be discarded, not queued.
REQ-024 Debounce during load: key debouncing SHALL continue while LOAD is high, so no stale press fires when LOAD falls.
REQ-025 changed pulse: changed SHALL be 1 in the cycle immediately after any edge where bin took a different value, and 0 otherwise.
REQ-026 Repeated load value: reloading the value bin already holds SHALL NOT pulse changed.
REQ-027 Output timing: bin and changed SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-028 With RESET=1 at a clock edge, the block SHALL set all of: bin=0, changed=0, both debounced levels=1, both debounce counters=0, all synchronizer flops=1 (keys) or 0 (LOAD, SW).
REQ-029 RESET SHALL override every other input in the same cycle.
REQ-030 A reset mid-debounce SHALL discard partial counts; a key still held low after reset SHALL need a full DEBOUNCE_CYCLES window and then count once.
REQ-031 After RESET falls, bin SHALL stay 0 until a qualifying press or a synchronized LOAD.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Clean press test: reset, then hold KEY_UP low from edge 10 -> bin=1 first at edge 17; changed=1 for the single cycle after edge 17; no further change while held.
REQ-033 Bounce test: KEY_UP toggling low 2 cycles / high 1 cycle for 12 cycles, then high -> bin stays 0; changed never asserts.
REQ-034 Wrap test: LOAD=1 with SW=15 for 4 cycles, then LOAD=0; one clean up press -> bin=0; one clean down press -> bin=15; changed pulses once per step.
REQ-035 Simultaneous test: bin=7; KEY_UP and KEY_DN fall on the same edge and both are held -> bin remains 7; changed stays 0.
REQ-036 Load-versus-press test: LOAD=1, SW=9; clean up press completes during load -> bin=9. After LOAD=0, no increment occurs; a new press -> bin=10.
REQ-037 Reset mid-debounce test: KEY_DN held low; RESET pulsed 2 cycles after the fall -> bin=0 after reset; bin=15 exactly DEBOUNCE_CYCLES+3 edges after RESET deasserts.
